// File: rtl/bmf_butterfly_pipe.sv
// Purpose : pipelined radix-2 butterfly, out_sum = a+b, out_diff = a-b, with optional LSB truncation.
// Latency : STAGES cycles from input transfer to output presentation; 1 beat/cycle sustained.
// Backpr. : skid-free elastic pipe, ready_i = !valid_i | ready_{i+1}; in_ready drops only when all stages are full.
//
// Ports:
//   clk, rst                 rising-edge clock, asynchronous active-high reset
//   in_valid/in_ready        input handshake; in_a, in_b unsigned W-bit operands
//   in_exact                 1 = use full operands, 0 = zero the low APPROX_LSB bits
//   out_valid/out_ready      output handshake
//   out_sum                  a+b, unsigned W+1 bits
//   out_diff                 a-b, two's complement W+1 bits
//   err_clr, err_cnt, err_max  approximation error monitor (clear, beat count, max |error|)
//
// Build option: define BMF_BUTTERFLY_ERR_MON_EN to build the error monitor;
// otherwise err_cnt/err_max read 0 and err_clr is ignored.
module bmf_butterfly_pipe #(
    parameter int W          = 4,
    parameter int APPROX_LSB = 2,
    parameter int STAGES     = 2
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [W-1:0] in_a,
    input  logic [W-1:0] in_b,
    input  logic         in_exact,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [W:0]   out_sum,
    output logic [W:0]   out_diff,
    input  logic         err_clr,
    output logic [15:0]  err_cnt,
    output logic [W:0]   err_max
);
    // Bits kept in approximate mode; all ones when APPROX_LSB = 0.
    localparam logic [W-1:0] KEEP_MASK = {W{1'b1}} << APPROX_LSB;

    typedef struct packed {
        logic [W:0] sum;
        logic [W:0] diff;
`ifdef BMF_BUTTERFLY_ERR_MON_EN
        logic [W:0] err;
`endif
    } beat_t;

    logic [W-1:0]      am;
    logic [W-1:0]      bm;
    beat_t             s0_beat;
    logic              rdy_acc;
    logic [STAGES-1:0] stage_rdy;
    logic [STAGES-1:0] valid_q;
    logic [STAGES-1:0] valid_d;
    beat_t             beat_q [STAGES];
    beat_t             beat_d [STAGES];

    // All arithmetic happens here; later stages only carry the result.
    always_comb begin
        am           = in_exact ? in_a : (in_a & KEEP_MASK);
        bm           = in_exact ? in_b : (in_b & KEEP_MASK);
        s0_beat      = '0;
        s0_beat.sum  = {1'b0, am} + {1'b0, bm};
        s0_beat.diff = {1'b0, am} - {1'b0, bm};
`ifdef BMF_BUTTERFLY_ERR_MON_EN
        // Truncation only removes value, so exact - approx is never negative.
        s0_beat.err  = ({1'b0, in_a} + {1'b0, in_b}) - s0_beat.sum;
`endif
    end

    // Unrolled ready chain: stage i can load if any stage from i to the
    // output has a hole, or the output is being drained.
    always_comb begin
        stage_rdy = '0;
        rdy_acc   = out_ready;
        for (int i = STAGES - 1; i >= 0; i--) begin
            rdy_acc      = rdy_acc | ~valid_q[i];
            stage_rdy[i] = rdy_acc;
        end
    end

    // Data only moves on a transfer into a stage; bubbles keep stale data.
    always_comb begin
        valid_d = valid_q;
        beat_d  = beat_q;
        if (stage_rdy[0]) begin
            valid_d[0] = in_valid;
            if (in_valid) begin
                beat_d[0] = s0_beat;
            end
        end
        for (int i = 1; i < STAGES; i++) begin
            if (stage_rdy[i]) begin
                valid_d[i] = valid_q[i-1];
                if (valid_q[i-1]) begin
                    beat_d[i] = beat_q[i-1];
                end
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            valid_q <= '0;
            for (int i = 0; i < STAGES; i++) begin
                beat_q[i] <= '0;
            end
        end else begin
            valid_q <= valid_d;
            beat_q  <= beat_d;
        end
    end

    assign in_ready  = stage_rdy[0];
    assign out_valid = valid_q[STAGES-1];
    assign out_sum   = beat_q[STAGES-1].sum;
    assign out_diff  = beat_q[STAGES-1].diff;

`ifdef BMF_BUTTERFLY_ERR_MON_EN
    logic [15:0] err_cnt_q;
    logic [15:0] err_cnt_d;
    logic [W:0]  err_max_q;
    logic [W:0]  err_max_d;
    logic [W:0]  out_err;

    assign out_err = beat_q[STAGES-1].err;

    // Error is accounted when the beat leaves; a clear overrides that update.
    always_comb begin
        err_cnt_d = err_cnt_q;
        err_max_d = err_max_q;
        if (err_clr) begin
            err_cnt_d = '0;
            err_max_d = '0;
        end else if (out_valid && out_ready && (out_err != '0)) begin
            if (err_cnt_q != 16'hFFFF) begin
                err_cnt_d = err_cnt_q + 16'd1;
            end
            if (out_err > err_max_q) begin
                err_max_d = out_err;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            err_cnt_q <= '0;
            err_max_q <= '0;
        end else begin
            err_cnt_q <= err_cnt_d;
            err_max_q <= err_max_d;
        end
    end

    assign err_cnt = err_cnt_q;
    assign err_max = err_max_q;
`else
    logic unused_err_clr;
    assign unused_err_clr = err_clr;
    assign err_cnt        = '0;
    assign err_max        = '0;
`endif

endmodule

// File: tb/tb_bmf_butterfly_pipe.sv
// Self-checking bench for bmf_butterfly_pipe: a reference model fills a
// scoreboard on every input transfer; a negedge monitor pops and compares on
// every output transfer and checks output stability during stalls.
module tb_bmf_butterfly_pipe;
    localparam int W = 4;
    localparam int K = 2;
    localparam int S = 2;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         in_valid = 1'b0;
    logic         in_ready;
    logic [W-1:0] in_a = '0;
    logic [W-1:0] in_b = '0;
    logic         in_exact = 1'b0;
    logic         out_valid;
    logic         out_ready = 1'b0;
    logic [W:0]   out_sum;
    logic [W:0]   out_diff;
    logic         err_clr = 1'b0;
    logic [15:0]  err_cnt;
    logic [W:0]   err_max;

    bmf_butterfly_pipe #(.W(W), .APPROX_LSB(K), .STAGES(S)) dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_a(in_a), .in_b(in_b), .in_exact(in_exact),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_sum(out_sum), .out_diff(out_diff),
        .err_clr(err_clr), .err_cnt(err_cnt), .err_max(err_max)
    );

    always #5 clk = ~clk;

    typedef struct {
        int sum;
        int diff;
        int err;
    } exp_t;

    exp_t sb[$];
    int   tests = 0;
    int   fails = 0;
    int   n_in  = 0;
    int   n_out = 0;
    int   m_cnt = 0;
    int   m_max = 0;
    bit   hold_vld = 0;
    int   hold_sum = 0;
    int   hold_diff = 0;
    bit   done = 0;

    task automatic check(input string name, input int act, input int exp_v);
        tests++;
        if (act != exp_v) begin
            fails++;
            $display("FAIL %s: got %0d, expected %0d at %0t", name, act, exp_v, $time);
        end
    endtask

    // Reference: plain integer arithmetic on the masked operands.
    function automatic exp_t model(input int a, input int b, input bit ex);
        exp_t e;
        int   lowmask;
        int   am;
        int   bm;
        lowmask = ex ? 0 : ((1 << K) - 1);
        am      = a & ~lowmask;
        bm      = b & ~lowmask;
        e.sum   = am + bm;
        e.diff  = (am - bm) & ((1 << (W + 1)) - 1);
        e.err   = (a + b) - e.sum;
        return e;
    endfunction

    always @(negedge clk) begin
        if (rst) begin
            sb.delete();
            hold_vld = 0;
            m_cnt    = 0;
            m_max    = 0;
        end else begin
            if (hold_vld) begin
                check("stall_valid", int'(out_valid), 1);
                check("stall_sum", int'(out_sum), hold_sum);
                check("stall_diff", int'(out_diff), hold_diff);
            end
            hold_vld  = out_valid && !out_ready;
            hold_sum  = int'(out_sum);
            hold_diff = int'(out_diff);

            check("err_cnt", int'(err_cnt), m_cnt);
            check("err_max", int'(err_max), m_max);

            if (in_valid && in_ready) begin
                sb.push_back(model(int'(in_a), int'(in_b), in_exact));
                n_in++;
            end

            if (out_valid && out_ready) begin
                n_out++;
                if (sb.size() == 0) begin
                    tests++;
                    fails++;
                    $display("FAIL unexpected_out: got beat sum=%0d, expected none", out_sum);
                end else begin
                    exp_t e;
                    e = sb.pop_front();
                    check("sum", int'(out_sum), e.sum);
                    check("diff", int'(out_diff), e.diff);
`ifdef BMF_BUTTERFLY_ERR_MON_EN
                    if (!err_clr && e.err != 0) begin
                        if (m_cnt < 65535) m_cnt++;
                        if (e.err > m_max) m_max = e.err;
                    end
`endif
                end
            end
`ifdef BMF_BUTTERFLY_ERR_MON_EN
            if (err_clr) begin
                m_cnt = 0;
                m_max = 0;
            end
`endif
        end
    end

    task automatic send(input int a, input int b, input bit ex);
        bit acc;
        int budget;
        in_a     = a[W-1:0];
        in_b     = b[W-1:0];
        in_exact = ex;
        in_valid = 1'b1;
        acc      = 0;
        budget   = 0;
        while (!acc && budget < 200) begin
            @(negedge clk);
            acc = in_ready;
            @(posedge clk);
            #1;
            budget++;
        end
        in_valid = 1'b0;
        if (!acc) begin
            tests++;
            fails++;
            $display("FAIL send_timeout: in_ready stayed 0, expected 1 within 200 cycles");
        end
    endtask

    task automatic wait_out();
        int n = 0;
        while (!out_valid && n < 50) begin
            @(posedge clk);
            #1;
            n++;
        end
        if (!out_valid) begin
            tests++;
            fails++;
            $display("FAIL wait_out_timeout: out_valid=0, expected 1 within 50 cycles");
        end
    endtask

    task automatic drain();
        int n = 0;
        while (sb.size() != 0 && n < 500) begin
            @(posedge clk);
            #1;
            n++;
        end
        check("drain_left", sb.size(), 0);
    endtask

    initial begin
        #5ms;
        $display("FAIL watchdog: simulation still running, expected completion");
        $display("[TB] %0d tests run, %0d failed", tests, fails + 1);
        $fatal(1, "watchdog");
    end

    initial begin
        int lat;
        int n0;
        int seen;

        // Reset state
        repeat (3) @(posedge clk);
        #1;
        check("rst_out_valid", int'(out_valid), 0);
        check("rst_out_sum", int'(out_sum), 0);
        check("rst_out_diff", int'(out_diff), 0);
        check("rst_err_cnt", int'(err_cnt), 0);
        check("rst_err_max", int'(err_max), 0);
        rst = 1'b0;
        #1;
        check("rst_in_ready", int'(in_ready), 1);

        // Exact beat and its latency
        out_ready = 1'b1;
        send(9, 5, 1'b1);
        lat = 1;
        while (!out_valid && lat < 20) begin
            @(posedge clk);
            #1;
            lat++;
        end
        check("latency", lat, S);
        check("t1_sum", int'(out_sum), 14);
        check("t1_diff", int'(out_diff), 4);

        // Approximate beat
        send(7, 6, 1'b0);
        wait_out();
        check("t2_sum", int'(out_sum), 8);
        check("t2_diff", int'(out_diff), 0);
        @(posedge clk);
        #1;
`ifdef BMF_BUTTERFLY_ERR_MON_EN
        check("t2_err_cnt", int'(err_cnt), 1);
        check("t2_err_max", int'(err_max), 5);
`else
        check("t2_err_cnt", int'(err_cnt), 0);
        check("t2_err_max", int'(err_max), 0);
`endif

        // Negative difference and maximum sum
        send(0, 15, 1'b1);
        wait_out();
        check("t3_diff", int'(out_diff), 17);
        check("t3_sum", int'(out_sum), 15);
        send(15, 15, 1'b1);
        wait_out();
        check("t3_sum_max", int'(out_sum), 30);
        drain();

        // Stall: only S beats enter before in_ready drops
        out_ready = 1'b0;
        fork
            begin
                for (int k = 0; k < 8; k++) send($urandom_range(0, 15), $urandom_range(0, 15), 1'($urandom_range(0, 1)));
            end
            begin
                n0 = n_in;
                repeat (5) @(posedge clk);
                #1;
                check("stall_accepted", n_in - n0, S);
                check("stall_in_ready", int'(in_ready), 0);
                out_ready = 1'b1;
            end
        join
        drain();

        // Reset with beats in flight
        out_ready = 1'b0;
        send(3, 4, 1'b1);
        send(5, 6, 1'b1);
        rst = 1'b1;
        #1;
        check("midrst_out_valid", int'(out_valid), 0);
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        out_ready = 1'b1;
        seen = 0;
        repeat (10) begin
            @(negedge clk);
            if (out_valid) seen++;
        end
        check("midrst_stale", seen, 0);
        @(posedge clk);
        #1;

        // Random traffic with random back-pressure and clears
        done = 0;
        fork
            begin
                for (int k = 0; k < 400; k++) begin
                    repeat ($urandom_range(0, 2)) begin
                        @(posedge clk);
                        #1;
                    end
                    send($urandom_range(0, 15), $urandom_range(0, 15), 1'($urandom_range(0, 1)));
                end
                done = 1;
            end
            begin
                while (!done) begin
                    @(posedge clk);
                    #1;
                    out_ready = ($urandom_range(0, 3) != 0);
                    err_clr   = ($urandom_range(0, 15) == 0);
                end
                out_ready = 1'b1;
                err_clr   = 1'b0;
            end
        join
        drain();

`ifdef BMF_BUTTERFLY_ERR_MON_EN
        // Saturation, then clear
        out_ready = 1'b1;
        for (int k = 0; k < 70000; k++) send(7, 6, 1'b0);
        drain();
        repeat (2) @(posedge clk);
        #1;
        check("sat_err_cnt", int'(err_cnt), 65535);
        check("sat_err_max", int'(err_max), 5);
        err_clr = 1'b1;
        @(posedge clk);
        #1;
        err_clr = 1'b0;
        check("clr_err_cnt", int'(err_cnt), 0);
        check("clr_err_max", int'(err_max), 0);
`endif

        repeat (3) @(posedge clk);
        #1;
        check("in_out_balance", n_out, n_in - 2);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
